// File: rtl/fetch_stage_pkg.sv
// Shared widths, the NOP encoding and the credit helper for the fetch stage.
package fetch_stage_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Slots committed next cycle: queued words plus the in-flight read, minus a word leaving now.
  function automatic logic [2:0] credit_used(input logic [1:0] count,
                                             input logic       req,
                                             input logic       pop);
    return {1'b0, count} + {2'b00, req} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry FIFO holding fetched {instr, pc} words; flush empties it in one cycle.
module fetch_fifo2 #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_q] = din;
        wr_d        = ~wr_q;
      end
      if (pop) begin
        rd_d = ~rd_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // The credit rule in the parent must keep a full queue from ever seeing a push.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && count_q == 2'd2));
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: drives the PC, tracks one in-flight imem read, queues words for decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_q,
  output logic               pc_en,
  output logic               pc_aload,
  output logic [ADDR_W-1:0]  pc_d,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_addr,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
);

  localparam int ENT_W = INSTR_W + ADDR_W;

  logic              req_q, req_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [1:0]        count;
  logic [ENT_W-1:0]  head;
  logic              pop, issue, redir;

  // Issue stage: address goes out on pc_q, PC steps unless a redirect reloads it.
  always_comb begin
    redir    = redir_valid & ~rst;
    pop      = (count != 2'd0) & if_ready & ~rst;
    issue    = ~rst & ~redir_valid & (credit_used(count, req_q, pop) <= 3'd1);
    req_d    = issue;
    req_pc_d = issue ? pc_q : req_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 1'b0;
    end else begin
      req_q <= req_d;
    end
  end

  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
  end

  // Return stage: registered read data lands in the queue unless a redirect discards it.
  fetch_fifo2 #(.W(ENT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_q),
    .pop   (pop),
    .flush (redir),
    .din   ({imem_rdata, req_pc_q}),
    .count (count),
    .head  (head)
  );

  assign pc_en     = issue;
  assign pc_aload  = redir;
  assign pc_d      = rst ? '0 : redir_addr;
  assign imem_addr = pc_q;
  assign if_valid  = ~rst & (count != 2'd0);
  assign if_instr  = rst ? INSTR_W'(NOP) : head[ENT_W-1:ADDR_W];
  assign if_pc     = rst ? '0 : head[ADDR_W-1:0];

endmodule
